// File: rtl/bcd_operand_entry.sv
// Keypad front end for the BCD ALU: collects digit/operator keys into two
// packed-BCD operands plus add/sub select and strobes op_valid on EQUALS.
module bcd_operand_entry #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   bcd_A,
  output logic [4*DIGITS-1:0]   bcd_B,
  output logic                  ctrl,
  output logic                  op_valid,
  output logic [4*DIGITS-1:0]   entry_disp,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [3:0] K_ADD   = 4'hA;
  localparam logic [3:0] K_SUB   = 4'hB;
  localparam logic [3:0] K_EQ    = 4'hC;
  localparam logic [3:0] K_CLEAR = 4'hD;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            ctrl_q, ctrl_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            opv_q, opv_d;
  logic            cnt_full;

  assign cnt_full = (cnt_q == CW'(DIGITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      opv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      opv_q   <= opv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    opv_d   = 1'b0;

    if (key_valid) begin
      if (key_code <= 4'd9) begin
        case (state_q)
          S_A: begin
            if (cnt_full) begin
              err_d = 1'b1;
            end else begin
              a_d   = {a_q[W-5:0], key_code};
              cnt_d = cnt_q + CW'(1);
            end
          end
          S_B: begin
            if (cnt_full) begin
              err_d = 1'b1;
            end else begin
              b_d   = {b_q[W-5:0], key_code};
              cnt_d = cnt_q + CW'(1);
            end
          end
          S_DONE: begin
            // A digit after an issue starts a fresh calculation
            a_d     = {{(W-4){1'b0}}, key_code};
            b_d     = '0;
            ctrl_d  = 1'b0;
            cnt_d   = CW'(1);
            state_d = S_A;
          end
          default: state_d = S_A;
        endcase
      end else if (key_code == K_ADD || key_code == K_SUB) begin
        // ADD/SUB differ only in bit 0, which is exactly the ctrl encoding
        case (state_q)
          S_A: begin
            ctrl_d  = key_code[0];
            b_d     = '0;
            cnt_d   = '0;
            state_d = S_B;
          end
          S_B:     ctrl_d = key_code[0];
          S_DONE:  err_d  = 1'b1;
          default: state_d = S_A;
        endcase
      end else if (key_code == K_EQ) begin
        case (state_q)
          S_A: err_d = 1'b1;
          S_B: begin
            state_d = S_DONE;
            opv_d   = 1'b1;
          end
          S_DONE:  opv_d = 1'b1;
          default: state_d = S_A;
        endcase
      end else if (key_code == K_CLEAR) begin
        state_d = S_A;
        a_d     = '0;
        b_d     = '0;
        ctrl_d  = 1'b0;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
    end
  end

  assign bcd_A      = a_q;
  assign bcd_B      = b_q;
  assign ctrl       = ctrl_q;
  assign op_valid   = opv_q;
  assign err        = err_q;
  assign entry_disp = (state_q == S_A) ? a_q : b_q;

endmodule
